// File: rtl/alu_decode_stage.sv
// RV32I integer-compute decode stage: turns one instruction plus its register
// operands into ALU controls and operands, presented through a valid/ready register.
module alu_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_op_a,
    output logic [XLEN-1:0] o_op_b,
    output logic            o_sub,
    output logic [1:0]      o_bool_op,
    output logic [3:0]      o_op_sel,
    output logic            o_shift_dir,
    output logic            o_cmp_unsigned,
    output logic [4:0]      o_rd,
    output logic            o_wen,
    output logic            o_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] SEL_ADD   = 4'b0001;
    localparam logic [3:0] SEL_CMP   = 4'b0010;
    localparam logic [3:0] SEL_BOOL  = 4'b0100;
    localparam logic [3:0] SEL_SHIFT = 4'b1000;

    localparam logic [1:0] BOOL_XOR = 2'b00;
    localparam logic [1:0] BOOL_OR  = 2'b10;
    localparam logic [1:0] BOOL_AND = 2'b11;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic       f3_is_shift;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt_imm;
    logic [XLEN-1:0] shamt_reg;

    assign opcode      = i_inst[6:0];
    assign f3          = i_inst[14:12];
    assign f7          = i_inst[31:25];
    assign rd          = i_inst[11:7];
    assign f3_is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    assign imm_i     = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
    assign imm_u     = {i_inst[31:12], 12'b0};
    assign shamt_imm = {{(XLEN-5){1'b0}}, i_inst[24:20]};
    // Register shifts only see rs2[4:0] so the ALU shifter never gets an amount above 31.
    assign shamt_reg = {{(XLEN-5){1'b0}}, i_rs2_data[4:0]};

    logic [XLEN-1:0] dec_op_a;
    logic [XLEN-1:0] dec_op_b;
    logic            dec_is_alu;
    logic            dec_is_reg;
    logic            dec_is_upper;
    logic            dec_f7_ok;
    logic            dec_legal;

    always_comb begin
        dec_op_a     = '0;
        dec_op_b     = '0;
        dec_is_alu   = 1'b0;
        dec_is_reg   = 1'b0;
        dec_is_upper = 1'b0;
        dec_f7_ok    = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_op_a   = i_rs1_data;
                dec_op_b   = f3_is_shift ? shamt_reg : i_rs2_data;
                dec_is_alu = 1'b1;
                dec_is_reg = 1'b1;
                dec_f7_ok  = (f7 == F7_BASE) ||
                             ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                dec_op_a   = i_rs1_data;
                dec_op_b   = f3_is_shift ? shamt_imm : imm_i;
                dec_is_alu = 1'b1;
                if (f3 == 3'b001) begin
                    dec_f7_ok = (f7 == F7_BASE);
                end else if (f3 == 3'b101) begin
                    dec_f7_ok = (f7 == F7_BASE) || (f7 == F7_ALT);
                end else begin
                    dec_f7_ok = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_op_b     = imm_u;
                dec_is_upper = 1'b1;
            end
            OPC_AUIPC: begin
                dec_op_a     = i_pc;
                dec_op_b     = imm_u;
                dec_is_upper = 1'b1;
            end
            default: begin
                dec_op_a = '0;
                dec_op_b = '0;
            end
        endcase
        dec_legal = dec_is_alu ? dec_f7_ok : dec_is_upper;
    end

    logic       dec_sub;
    logic [1:0] dec_bool_op;
    logic [3:0] dec_op_sel;
    logic       dec_shift_dir;
    logic       dec_cmp_unsigned;
    logic       dec_wen;

    // Illegal instructions leave every control at zero so the ALU produces 0.
    always_comb begin
        dec_sub          = 1'b0;
        dec_bool_op      = BOOL_XOR;
        dec_op_sel       = '0;
        dec_shift_dir    = 1'b0;
        dec_cmp_unsigned = 1'b0;
        if (dec_legal && !dec_is_alu) begin
            dec_op_sel = SEL_ADD;
        end else if (dec_legal) begin
            case (f3)
                3'b000: begin
                    dec_op_sel = SEL_ADD;
                    dec_sub    = dec_is_reg & f7[5];
                end
                3'b001: begin
                    dec_op_sel = SEL_SHIFT;
                end
                3'b010: begin
                    dec_op_sel = SEL_CMP;
                    dec_sub    = 1'b1;
                end
                3'b011: begin
                    dec_op_sel       = SEL_CMP;
                    dec_sub          = 1'b1;
                    dec_cmp_unsigned = 1'b1;
                end
                3'b100: begin
                    dec_op_sel  = SEL_BOOL;
                    dec_bool_op = BOOL_XOR;
                end
                3'b101: begin
                    dec_op_sel    = SEL_SHIFT;
                    dec_shift_dir = 1'b1;
                    dec_sub       = f7[5];
                end
                3'b110: begin
                    dec_op_sel  = SEL_BOOL;
                    dec_bool_op = BOOL_OR;
                end
                3'b111: begin
                    dec_op_sel  = SEL_BOOL;
                    dec_bool_op = BOOL_AND;
                end
            endcase
        end
        dec_wen = dec_legal && (rd != 5'd0);
    end

    logic            valid_q,        valid_d;
    logic [XLEN-1:0] op_a_q,         op_a_d;
    logic [XLEN-1:0] op_b_q,         op_b_d;
    logic            sub_q,          sub_d;
    logic [1:0]      bool_op_q,      bool_op_d;
    logic [3:0]      op_sel_q,       op_sel_d;
    logic            shift_dir_q,    shift_dir_d;
    logic            cmp_unsigned_q, cmp_unsigned_d;
    logic [4:0]      rd_q,           rd_d;
    logic            wen_q,          wen_d;
    logic            illegal_q,      illegal_d;
    logic            load;

    assign o_ready = ~valid_q | i_ready;
    assign load    = i_valid & o_ready & ~i_flush;

    // Payload only changes on a load, so a stalled entry stays bit-stable.
    always_comb begin
        valid_d        = valid_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        sub_d          = sub_q;
        bool_op_d      = bool_op_q;
        op_sel_d       = op_sel_q;
        shift_dir_d    = shift_dir_q;
        cmp_unsigned_d = cmp_unsigned_q;
        rd_d           = rd_q;
        wen_d          = wen_q;
        illegal_d      = illegal_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            op_a_d         = dec_op_a;
            op_b_d         = dec_op_b;
            sub_d          = dec_sub;
            bool_op_d      = dec_bool_op;
            op_sel_d       = dec_op_sel;
            shift_dir_d    = dec_shift_dir;
            cmp_unsigned_d = dec_cmp_unsigned;
            rd_d           = rd;
            wen_d          = dec_wen;
            illegal_d      = ~dec_legal;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q        <= 1'b0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            sub_q          <= 1'b0;
            bool_op_q      <= '0;
            op_sel_q       <= '0;
            shift_dir_q    <= 1'b0;
            cmp_unsigned_q <= 1'b0;
            rd_q           <= '0;
            wen_q          <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            sub_q          <= sub_d;
            bool_op_q      <= bool_op_d;
            op_sel_q       <= op_sel_d;
            shift_dir_q    <= shift_dir_d;
            cmp_unsigned_q <= cmp_unsigned_d;
            rd_q           <= rd_d;
            wen_q          <= wen_d;
            illegal_q      <= illegal_d;
        end
    end

    assign o_valid        = valid_q;
    assign o_op_a         = op_a_q;
    assign o_op_b         = op_b_q;
    assign o_sub          = sub_q;
    assign o_bool_op      = bool_op_q;
    assign o_op_sel       = op_sel_q;
    assign o_shift_dir    = shift_dir_q;
    assign o_cmp_unsigned = cmp_unsigned_q;
    assign o_rd           = rd_q;
    assign o_wen          = wen_q;
    assign o_illegal      = illegal_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed-vector bench for alu_decode_stage: decode cases, stall, flush,
// illegal encodings and reset in the middle of a stall.
module tb_alu_decode_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_inst;
    logic [31:0] i_pc;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_op_a;
    logic [31:0] o_op_b;
    logic        o_sub;
    logic [1:0]  o_bool_op;
    logic [3:0]  o_op_sel;
    logic        o_shift_dir;
    logic        o_cmp_unsigned;
    logic [4:0]  o_rd;
    logic        o_wen;
    logic        o_illegal;

    int checks = 0;
    int errors = 0;

    alu_decode_stage #(.XLEN(32)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_inst         (i_inst),
        .i_pc           (i_pc),
        .i_rs1_data     (i_rs1_data),
        .i_rs2_data     (i_rs2_data),
        .i_flush        (i_flush),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_op_a         (o_op_a),
        .o_op_b         (o_op_b),
        .o_sub          (o_sub),
        .o_bool_op      (o_bool_op),
        .o_op_sel       (o_op_sel),
        .o_shift_dir    (o_shift_dir),
        .o_cmp_unsigned (o_cmp_unsigned),
        .o_rd           (o_rd),
        .o_wen          (o_wen),
        .o_illegal      (o_illegal)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic ready, input logic flush);
        i_valid    = valid;
        i_inst     = inst;
        i_pc       = pc;
        i_rs1_data = rs1;
        i_rs2_data = rs2;
        i_ready    = ready;
        i_flush    = flush;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkDecode(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] sel, input logic sub, input logic [1:0] bop,
                               input logic dir, input logic uns, input logic [4:0] rd,
                               input logic wen);
        checkOutput({tag, ".valid"},   32'(o_valid),        32'd1);
        checkOutput({tag, ".op_a"},    o_op_a,              a);
        checkOutput({tag, ".op_b"},    o_op_b,              b);
        checkOutput({tag, ".op_sel"},  32'(o_op_sel),       32'(sel));
        checkOutput({tag, ".sub"},     32'(o_sub),          32'(sub));
        checkOutput({tag, ".bool_op"}, 32'(o_bool_op),      32'(bop));
        checkOutput({tag, ".dir"},     32'(o_shift_dir),    32'(dir));
        checkOutput({tag, ".uns"},     32'(o_cmp_unsigned), 32'(uns));
        checkOutput({tag, ".rd"},      32'(o_rd),           32'(rd));
        checkOutput({tag, ".wen"},     32'(o_wen),          32'(wen));
        checkOutput({tag, ".illegal"}, 32'(o_illegal),      32'd0);
    endtask

    task automatic checkIllegal(input string tag, input logic [4:0] rd);
        checkOutput({tag, ".valid"},   32'(o_valid),   32'd1);
        checkOutput({tag, ".illegal"}, 32'(o_illegal), 32'd1);
        checkOutput({tag, ".op_sel"},  32'(o_op_sel),  32'd0);
        checkOutput({tag, ".wen"},     32'(o_wen),     32'd0);
        checkOutput({tag, ".sub"},     32'(o_sub),     32'd0);
        checkOutput({tag, ".rd"},      32'(o_rd),      32'(rd));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".valid"},   32'(o_valid),   32'd0);
        checkOutput({tag, ".op_a"},    o_op_a,         32'd0);
        checkOutput({tag, ".op_b"},    o_op_b,         32'd0);
        checkOutput({tag, ".op_sel"},  32'(o_op_sel),  32'd0);
        checkOutput({tag, ".ctrl"},    32'({o_sub, o_bool_op, o_shift_dir, o_cmp_unsigned}), 32'd0);
        checkOutput({tag, ".rd"},      32'(o_rd),      32'd0);
        checkOutput({tag, ".wen"},     32'(o_wen),     32'd0);
        checkOutput({tag, ".illegal"}, 32'(o_illegal), 32'd0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        i_rst = 1'b1;
        idle();
        tick();
        tick();
        i_rst = 1'b0;
        checkAllZero("reset");
        checkOutput("reset.ready", 32'(o_ready), 32'd1);

        // add x3,x1,x2
        applyStimulus(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0);
        tick();
        idle();
        checkDecode("add", 32'd5, 32'd7, 4'b0001, 1'b0, 2'b00, 1'b0, 1'b0, 5'd3, 1'b1);
        tick();
        checkOutput("add.drain", 32'(o_valid), 32'd0);

        // srai x1,x1,31 then sll x4,x1,x2 back to back
        applyStimulus(1'b1, 32'h41F0D093, 32'h0, 32'h80000000, 32'h0, 1'b1, 1'b0);
        tick();
        checkDecode("srai", 32'h80000000, 32'h1F, 4'b1000, 1'b1, 2'b00, 1'b1, 1'b0, 5'd1, 1'b1);
        applyStimulus(1'b1, 32'h00209233, 32'h0, 32'h11, 32'hFFFFFFE3, 1'b1, 1'b0);
        tick();
        checkDecode("sll", 32'h11, 32'h3, 4'b1000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd4, 1'b1);

        // sltu x5,x6,x7
        applyStimulus(1'b1, 32'h007332B3, 32'h0, 32'd9, 32'd10, 1'b1, 1'b0);
        tick();
        checkDecode("sltu", 32'd9, 32'd10, 4'b0010, 1'b1, 2'b00, 1'b0, 1'b1, 5'd5, 1'b1);

        // ori x1,x2,-1
        applyStimulus(1'b1, 32'hFFF16093, 32'h0, 32'h1234, 32'h0, 1'b1, 1'b0);
        tick();
        checkDecode("ori", 32'h1234, 32'hFFFFFFFF, 4'b0100, 1'b0, 2'b10, 1'b0, 1'b0, 5'd1, 1'b1);

        // auipc x7,0x1 at pc 0x100
        applyStimulus(1'b1, 32'h00001397, 32'h100, 32'hAAAA, 32'h0, 1'b1, 1'b0);
        tick();
        checkDecode("auipc", 32'h100, 32'h1000, 4'b0001, 1'b0, 2'b00, 1'b0, 1'b0, 5'd7, 1'b1);

        // add x0,x1,x2: legal but no writeback
        applyStimulus(1'b1, 32'h00208033, 32'h0, 32'd1, 32'd2, 1'b1, 1'b0);
        tick();
        checkDecode("add_x0", 32'd1, 32'd2, 4'b0001, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
        idle();
        tick();

        // Stall: first add held three cycles while sub x8,x9,x10 waits upstream
        applyStimulus(1'b1, 32'h002081B3, 32'h0, 32'd1, 32'd2, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h40A48433, 32'h0, 32'd100, 32'd30, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkDecode("stall", 32'd1, 32'd2, 4'b0001, 1'b0, 2'b00, 1'b0, 1'b0, 5'd3, 1'b1);
            checkOutput("stall.ready", 32'(o_ready), 32'd0);
            tick();
        end
        i_ready = 1'b1;
        #1;
        checkOutput("stall.release_ready", 32'(o_ready), 32'd1);
        tick();
        idle();
        checkDecode("sub", 32'd100, 32'd30, 4'b0001, 1'b1, 2'b00, 1'b0, 1'b0, 5'd8, 1'b1);
        tick();
        checkOutput("sub.drain", 32'(o_valid), 32'd0);

        // Flush with an incoming instruction drops it
        applyStimulus(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b1);
        tick();
        idle();
        checkOutput("flush_in.valid", 32'(o_valid), 32'd0);
        // Flush while an entry is stalled discards it
        applyStimulus(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0);
        tick();
        checkOutput("flush_held.pre", 32'(o_valid), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("flush_held.valid", 32'(o_valid), 32'd0);
        idle();

        // Illegal encodings still travel as payloads
        applyStimulus(1'b1, 32'h4000C0B3, 32'h0, 32'd3, 32'd4, 1'b1, 1'b0);
        tick();
        checkIllegal("ill_xor_f7", 5'd1);
        applyStimulus(1'b1, 32'h123452B7, 32'h0, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0);
        tick();
        checkDecode("lui", 32'h0, 32'h12345000, 4'b0001, 1'b0, 2'b00, 1'b0, 1'b0, 5'd5, 1'b1);
        applyStimulus(1'b1, 32'h00000083, 32'h0, 32'd1, 32'd1, 1'b1, 1'b0);
        tick();
        checkIllegal("ill_load", 5'd1);
        applyStimulus(1'b1, 32'h40001093, 32'h0, 32'd1, 32'd1, 1'b1, 1'b0);
        tick();
        checkIllegal("ill_slli_f7", 5'd1);
        idle();
        tick();

        // Reset while stalled, then a normal decode
        applyStimulus(1'b1, 32'h41F0D093, 32'h0, 32'h80000000, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("rst_stall.pre", 32'(o_valid), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checkAllZero("rst_stall");
        applyStimulus(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0);
        tick();
        idle();
        checkDecode("post_rst", 32'd5, 32'd7, 4'b0001, 1'b0, 2'b00, 1'b0, 1'b0, 5'd3, 1'b1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Registered decode stage that produces the ALU control and operand interface: i_sub, i_bool_op, i_op_sel, i_shift_dir, op A and op B.
- Accepts one RV32I integer-compute instruction per handshake and decodes it to ALU controls and operands.
- Presents the result one cycle later through a valid/ready pipeline register.
- Sits between register-file read and execute.

Parameters:
XLEN, 32, datapath width (only 32 supported)

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_valid  input  1  upstream instruction valid
o_ready  output  1  stage can accept
i_inst  input  32  instruction word
i_pc  input  32  instruction address
i_rs1_data  input  32  rs1 read value
i_rs2_data  input  32  rs2 read value
i_flush  input  1  kill held/incoming instruction
o_valid  output  1  decoded payload valid
i_ready  input  1  execute accepts payload
o_op_a  output  32  ALU operand A
o_op_b  output  32  ALU operand B
o_sub  output  1  ALU subtract / arithmetic-shift select
o_bool_op  output  2  00 xor, 10 or, 11 and
o_op_sel  output  4  one-hot: [0] add, [1] compare, [2] bool, [3] shift
o_shift_dir  output  1  0 left, 1 right
o_cmp_unsigned  output  1  SLTU when o_op_sel[1]
o_rd  output  5  destination register
o_wen  output  1  register writeback enable
o_illegal  output  1  undecodable instruction

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - All state updates on the rising edge of i_clk.
  - Reset clears o_valid and every payload output to 0.
  - Reset has priority over flush and load. An instruction held mid-stall is discarded.
- Handshake:
  - o_ready = ~o_valid | i_ready (combinational).
  - Load occurs when i_valid & o_ready & ~i_flush.
  - Latency is 1 cycle: an instruction accepted in cycle N is presented in cycle N+1.
  - While o_valid & ~i_ready, the payload is held bit-stable.
  - If no load occurs and i_ready is high, o_valid falls to 0. The payload may hold stale values.
- Flush:
  - i_flush forces o_valid=0 next cycle.
  - An incoming instruction in the same cycle is dropped.
  - Flush with no instruction held is harmless.
- Decode, opcode = i_inst[6:0], f3 = [14:12], f7 = [31:25]:
  - OP (0110011): A=rs1, B=rs2. f7 must be 0000000, except 0100000, which is legal only for f3 000 (SUB) and 101 (SRA).
  - OP-IMM (0010011): A=rs1, B = sign-extended inst[31:20].
    - Shifts (f3 001/101): B = zero-extended shamt inst[24:20].
    - f3 001 requires f7 = 0000000.
    - f3 101 requires f7 = 0000000 (SRLI) or 0100000 (SRAI).
  - LUI (0110111): A=0, B = {inst[31:12], 12'b0}, op_sel=add.
  - AUIPC (0010111): A=i_pc, B = same U-immediate, op_sel=add.
- f3 mapping:
  - 000 add; o_sub=1 only for OP with f7=0100000.
  - 001 shift, dir 0.
  - 010 compare, sub=1, unsigned=0.
  - 011 compare, sub=1, unsigned=1.
  - 100 bool 00.
  - 101 shift, dir 1; sub=1 for arithmetic.
  - 110 bool 10.
  - 111 bool 11.
- Register-shift operand B: o_op_b bits [31:5] are forced to 0, so the ALU's 6-bit shift amount never exceeds 31.
- Unused controls are 0: o_sub=0 for bool ops, o_bool_op=00 for non-bool ops, o_shift_dir=0 for non-shifts.
- o_rd = inst[11:7] for all instructions. o_wen = legal & (rd != 0).
- Illegal instruction:
  - Any other opcode or an invalid f7 sets o_illegal=1.
  - o_op_sel=0000 (ALU result 0), o_wen=0, o_sub=0.
  - The instruction still passes the handshake as a normal payload.

Test Plan:
1. ADD, 0x002081B3 (add x3,x1,x2), rs1=5, rs2=7, i_ready=1 -> next cycle o_valid=1, A=5, B=7, op_sel=0001, sub=0, rd=3, wen=1.
2. SRAI, 0x41F0D093 (srai x1,x1,31), rs1=0x80000000 -> B=0x1F, op_sel=1000, dir=1, sub=1; SLL with rs2=0xFFFFFFE3 -> B=0x03.
3. Stall: accept an instruction with i_ready=0 held 3 cycles, upstream offering a second instruction -> payload unchanged, o_ready=0; on i_ready=1 the second instruction is loaded and appears the following cycle.
4. Flush: i_flush=1 in the same cycle as i_valid=1 with o_ready=1 -> o_valid=0 next cycle; no payload reaches execute.
5. Illegal: 0x4000C0B3 (f7=0100000, f3=100) -> o_illegal=1, op_sel=0000, wen=0, o_valid=1. LUI x5,0x12345 (0x123452B7) -> A=0, B=0x12345000, wen=1.
6. Reset mid-stall: o_valid=1, i_ready=0, assert i_rst one cycle -> next cycle o_valid=0 and all outputs 0. The next accepted instruction decodes normally.
